// File: rtl/arb_pkg.sv
// Shared sizes, state encoding and priority helper for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index of the lowest set bit; bit 0 has the highest priority. Returns 0 for an empty vector.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                pos = IDX_W'(i);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/idx_decode3_8.sv
// 3:8 index decoder with enable; produces a one-hot vector, or zero when disabled.
module idx_decode3_8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
        assign onehot[gi] = en && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a programmable per-grant hold limit.
// Every grant is followed by one IDLE cycle, where the next winner is chosen.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic             HOLD_ON  = (HOLD_MAX != 0);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] sel_off;
    logic [IDX_W-1:0] sel_idx;
    logic             any_req;
    logic             hold_hit;
    logic             release_now;

    // Rotate so that requester ptr lands on bit 0; the 3-bit sum wraps 7 -> 0.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_q + IDX_W'(gi)];
    end

    assign any_req     = |req;
    assign sel_off     = lowest_set(req_rot);
    assign sel_idx     = ptr_q + sel_off;
    assign hold_hit    = HOLD_ON && (cnt_q == HOLD_LIM);
    assign release_now = !req[gnt_idx_q] || !en || hold_hit;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            IDLE: begin
                gnt_valid_d = 1'b0;
                if (en && any_req) begin
                    state_d     = GRANT;
                    gnt_idx_d   = sel_idx;
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                    ptr_d       = sel_idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    idx_decode3_8 u_gnt_dec (
        .idx    (gnt_idx_q),
        .en     (gnt_valid_q),
        .onehot (gnt)
    );

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with three hold limits (0 = unlimited, 1, 3) driven in parallel.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;

    logic [7:0] gnt_h0, gnt_h1, gnt_h3;
    logic [2:0] idx_h0, idx_h1, idx_h3;
    logic       vld_h0, vld_h1, vld_h3;

    int checks_cnt = 0;
    int errors_cnt = 0;

    rr_arbiter8 #(.HOLD_MAX(0)) dut_h0 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_h0), .gnt_idx(idx_h0), .gnt_valid(vld_h0)
    );
    rr_arbiter8 #(.HOLD_MAX(1)) dut_h1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_h1), .gnt_idx(idx_h1), .gnt_valid(vld_h1)
    );
    rr_arbiter8 #(.HOLD_MAX(3)) dut_h3 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_h3), .gnt_idx(idx_h3), .gnt_valid(vld_h3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Inputs change at negedge; outputs are observed at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_g;
        logic [2:0] seq81 [4];
        seq81[0] = 3'd0; seq81[1] = 3'd7; seq81[2] = 3'd0; seq81[3] = 3'd7;

        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        @(negedge clk);

        // Reset held with all requests and enable high.
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("rst_gnt", {24'd0, gnt_h0}, 32'h00);
            check_val("rst_vld", {31'd0, vld_h0}, 32'd0);
            check_val("rst_idx", {29'd0, idx_h0}, 32'd0);
        end
        rst = 1'b0;
        check_val("rst_rel_gnt", {24'd0, gnt_h1}, 32'h00);
        tick();
        check_val("rst_first_gnt", {24'd0, gnt_h0}, 32'h01);
        check_val("rst_first_idx", {29'd0, idx_h3}, 32'd0);

        // Single requester, unlimited hold.
        do_reset();
        req = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("single_gnt_%0d", i), {24'd0, gnt_h0}, 32'h10);
            check_val($sformatf("single_idx_%0d", i), {29'd0, idx_h0}, 32'd4);
        end
        req = 8'h00;
        tick();
        check_val("single_drop_gnt", {24'd0, gnt_h0}, 32'h00);
        check_val("single_drop_vld", {31'd0, vld_h0}, 32'd0);
        check_val("single_drop_idx", {29'd0, idx_h0}, 32'd4);

        // Rotation with all requesting, hold limit 1.
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_val($sformatf("rot_ff_idx_%0d", k), {29'd0, idx_h1}, 32'(k % 8));
            check_val($sformatf("rot_ff_vld_%0d", k), {31'd0, vld_h1}, 32'd1);
            tick();
            check_val($sformatf("rot_ff_dead_%0d", k), {24'd0, gnt_h1}, 32'h00);
        end

        do_reset();
        req = 8'h81;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_g = 8'h01 << seq81[k];
            check_val($sformatf("rot_81_gnt_%0d", k), {24'd0, gnt_h1}, {24'd0, exp_g});
            tick();
            check_val($sformatf("rot_81_dead_%0d", k), {24'd0, gnt_h1}, 32'h00);
        end

        // Hold limit 3 with two requesters.
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("hold_a_%0d", i), {24'd0, gnt_h3}, 32'h01);
        end
        tick();
        check_val("hold_dead_a", {24'd0, gnt_h3}, 32'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("hold_b_%0d", i), {24'd0, gnt_h3}, 32'h02);
        end
        tick();
        check_val("hold_dead_b", {24'd0, gnt_h3}, 32'h00);
        tick();
        check_val("hold_again", {24'd0, gnt_h3}, 32'h01);

        // Enable dropped during a grant on index 5.
        do_reset();
        req = 8'h20;
        tick();
        check_val("en_grant", {24'd0, gnt_h0}, 32'h20);
        tick();
        check_val("en_hold", {24'd0, gnt_h0}, 32'h20);
        en = 1'b0;
        tick();
        check_val("en_off_gnt", {24'd0, gnt_h0}, 32'h00);
        tick();
        check_val("en_off_stay", {31'd0, vld_h0}, 32'd0);
        en = 1'b1;
        tick();
        check_val("en_back_gnt", {24'd0, gnt_h0}, 32'h20);

        // Reset during a grant returns the pointer to 0.
        do_reset();
        req = 8'h20;
        tick();
        check_val("rstmid_grant", {24'd0, gnt_h0}, 32'h20);
        rst = 1'b1;
        req = 8'hFF;
        tick();
        check_val("rstmid_gnt", {24'd0, gnt_h0}, 32'h00);
        rst = 1'b0;
        tick();
        check_val("rstmid_next_idx", {29'd0, idx_h0}, 32'd0);
        check_val("rstmid_next_vld", {31'd0, vld_h0}, 32'd1);

        // Pointer wrap from 7 and non-granted request toggling.
        do_reset();
        req = 8'h40;
        tick();
        check_val("wrap_g6", {24'd0, gnt_h0}, 32'h40);
        req = 8'h00;
        tick();
        check_val("wrap_rel", {24'd0, gnt_h0}, 32'h00);
        req = 8'h41;
        tick();
        check_val("wrap_g0", {24'd0, gnt_h0}, 32'h01);
        for (int i = 0; i < 4; i++) begin
            req = (i % 2 == 0) ? 8'h01 : 8'h41;
            tick();
            check_val($sformatf("ignore_%0d", i), {24'd0, gnt_h0}, 32'h01);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among 8 requesters. It picks one requester per grant and presents the grant both as a 3-bit index and as a one-hot vector produced by a 3:8 index decode. A grant is held until the requester releases it, until a programmable hold limit expires, or until the arbiter is disabled. The block sits between the 8 requesting agents and the shared resource select logic.

## Interface
- HOLD_MAX, default 15: maximum consecutive grant cycles per requester (range 1..15; 0 means unlimited).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable.
- req  input  8  request vector; req[i] high means requester i wants the resource.
- gnt  output  8  one-hot grant; all zeros when no grant is active.
- gnt_idx  output  3  index of the current or most recent grant.
- gnt_valid  output  1  high while a grant is active.

## Operation
- States: IDLE, GRANT. Internal registers: state, ptr[2:0] (highest-priority index), cnt[3:0] (grant-cycle count), gnt_idx, gnt_valid.
- Reset: state=IDLE, ptr=0, cnt=0, gnt_idx=0, gnt_valid=0, gnt=8'h00. Reset has priority over all other inputs.
- IDLE, en=1 and |req=1:
  - Select the first set bit of req, scanning ptr, ptr+1, … mod 8 (wrap 7→0).
  - Next cycle: state=GRANT, gnt_idx=selected index, gnt_valid=1, cnt=1, ptr=selected+1 mod 8.
- IDLE otherwise: remain in IDLE; gnt_valid=0.
- GRANT: release when any of the following holds at the clock edge:
  - req[gnt_idx]=0;
  - en=0;
  - HOLD_MAX≠0 and cnt==HOLD_MAX.
- On release: next state=IDLE, gnt_valid=0. gnt_idx keeps its last value; ptr is unchanged.
- If GRANT does not release: cnt increments and saturates at 15.
- gnt = one-hot decode of gnt_idx when gnt_valid=1, else 8'h00. It is derived combinationally from registered state, so it is glitch-free relative to clk.
- Changes on non-granted req bits during GRANT have no effect.
- Forced rotation: a requester still asserting req after HOLD_MAX re-competes from IDLE. Because ptr has already moved past it, it gets lowest priority.

## Timing
- Grant latency: req sampled high in IDLE at edge N → gnt_valid/gnt high after edge N, in the cycle following the request.
- Release latency: req[gnt_idx] low or en low sampled at edge M → gnt low after edge M.
- Dead cycle: exactly one IDLE cycle, with gnt=0, always separates two grants. This applies even when the same requester wins again.
- HOLD_MAX=k with the requester holding req: gnt is high for exactly k cycles, then low for 1 cycle.
- Simultaneous release and new requests: release takes effect first. New requests are arbitrated in the following IDLE cycle.
- With all 8 requesters continuously requesting and HOLD_MAX=1, the grant order is 0,1,2,…,7,0. Each requester is granted every 16 cycles.
- rst during GRANT: gnt drops after the same edge, and ptr returns to 0.

## Structure
- Shared package arb_pkg holds:
  - N_REQ=8, IDX_W=3, CNT_W=4;
  - state enum {IDLE, GRANT}.
- Sub-module idx_decode3_8: combinational. Inputs are a 3-bit index and an enable; output is 8-bit one-hot, or zero when disabled. It is instantiated once to drive gnt from gnt_idx and gnt_valid.
- Priority search: a rotate-by-ptr, fixed-priority, rotate-back scheme in the top module. No other sub-modules.

## Test plan
- Reset: assert rst 2 cycles with req=8'hFF, en=1 → gnt=8'h00, gnt_valid=0, gnt_idx=0 throughout and on the first cycle after release.
- Single requester: req=8'h10 held 5 cycles then dropped, HOLD_MAX=0 → gnt=8'h10 and gnt_idx=4 from cycle 2, low the cycle after req drops.
- Rotation: req=8'hFF constant, HOLD_MAX=1 → gnt_idx sequence 0,1,…,7,0 with a dead cycle between each grant. Repeat with req=8'h81 → 0,7,0,7.
- Hold limit: HOLD_MAX=3, req=8'h03 constant → gnt=8'h01 for 3 cycles, dead cycle, gnt=8'h02 for 3 cycles, dead cycle, gnt=8'h01.
- Enable and reset mid-grant: with grant active on index 5, drop en for 1 cycle → gnt=0 next cycle, no grant while en=0. Separately, assert rst mid-grant → gnt=0 next cycle, and the next grant with req=8'hFF goes to index 0.
- Wrap and ignore: ptr=7 after granting 6, req=8'h41 → grant 0. During that grant, toggling req[6] must not change gnt.
